// File: rtl/lsu_pkg.sv
// Shared types and constants for the RV32I load/store sequencer.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
    localparam logic [3:0] LD_MISALIGN   = 4'd4;
    localparam logic [3:0] LD_FAULT      = 4'd5;
    localparam logic [3:0] ST_MISALIGN   = 4'd6;
    localparam logic [3:0] ST_FAULT      = 4'd7;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: byte enables, store replication, load extraction/extension
// and the misalignment check for one access.
module lsu_align
    import lsu_pkg::*;
(
    input  size_e       size_i,
    input  logic        signed_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] sdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o,
    output logic        misaligned_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection, enables and extension for the current size/offset.
    always_comb begin
        case (off_i)
            2'd0:    byte_s = rdata_i[7:0];
            2'd1:    byte_s = rdata_i[15:8];
            2'd2:    byte_s = rdata_i[23:16];
            2'd3:    byte_s = rdata_i[31:24];
            default: byte_s = rdata_i[7:0];
        endcase
        if (off_i[1]) begin
            half_s = rdata_i[31:16];
        end else begin
            half_s = rdata_i[15:0];
        end

        case (size_i)
            SZ_B: begin
                be_o         = 4'b0001 << off_i;
                wdata_o      = {4{sdata_i[7:0]}};
                ldata_o      = signed_i ? {{24{byte_s[7]}}, byte_s} : {24'd0, byte_s};
                misaligned_o = 1'b0;
            end
            SZ_H: begin
                be_o         = 4'b0011 << off_i;
                wdata_o      = {2{sdata_i[15:0]}};
                ldata_o      = signed_i ? {{16{half_s[15]}}, half_s} : {16'd0, half_s};
                misaligned_o = off_i[0];
            end
            SZ_W: begin
                be_o         = 4'b1111;
                wdata_o      = sdata_i;
                ldata_o      = rdata_i;
                misaligned_o = (off_i != 2'd0);
            end
            default: begin
                be_o         = 4'b1111;
                wdata_o      = sdata_i;
                ldata_o      = rdata_i;
                misaligned_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store sequencer: decodes one memory op, runs a single
// req/ack bus transfer, and reports a writeback result or a synchronous exception.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_lb,
    input  logic        is_lh,
    input  logic        is_lw,
    input  logic        is_lbu,
    input  logic        is_lhu,
    input  logic        is_sb,
    input  logic        is_sh,
    input  logic        is_sw,
    input  logic [31:0] base,
    input  logic [31:0] offset,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic        done_valid,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        exc_valid,
    output logic [3:0]  exc_cause,
    output logic [31:0] exc_tval
);

    state_e           state_q;
    logic [31:0]      ea_q;
    logic [4:0]       rd_q;
    size_e            size_q;
    logic             signed_q;
    logic             we_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic [7:0]  strobes_s;
    logic        legal_s;
    size_e       dec_size_s;
    logic        dec_signed_s;
    logic        dec_we_s;
    logic [31:0] ea_s;

    size_e       al_size_s;
    logic        al_signed_s;
    logic [1:0]  al_off_s;
    logic [3:0]  al_be_s;
    logic [31:0] al_wdata_s;
    logic [31:0] al_ldata_s;
    logic        al_mis_s;

    // Decode the strobes and form the effective address of the presented op.
    always_comb begin
        strobes_s    = {is_lb, is_lh, is_lw, is_lbu, is_lhu, is_sb, is_sh, is_sw};
        legal_s      = (strobes_s != 8'd0) && ((strobes_s & (strobes_s - 8'd1)) == 8'd0);
        dec_signed_s = is_lb | is_lh;
        dec_we_s     = is_sb | is_sh | is_sw;
        ea_s         = base + offset;
        if (is_lw || is_sw) begin
            dec_size_s = SZ_W;
        end else if (is_lh || is_lhu || is_sh) begin
            dec_size_s = SZ_H;
        end else begin
            dec_size_s = SZ_B;
        end
        cnt_d = cnt_q + CNT_W'(1);
    end

    // The aligner sees the live op while idle (bus setup) and the captured op afterwards (load extension).
    always_comb begin
        if (state_q == ST_IDLE) begin
            al_size_s   = dec_size_s;
            al_signed_s = dec_signed_s;
            al_off_s    = ea_s[1:0];
        end else begin
            al_size_s   = size_q;
            al_signed_s = signed_q;
            al_off_s    = ea_q[1:0];
        end
    end

    lsu_align u_align (
        .size_i       (al_size_s),
        .signed_i     (al_signed_s),
        .off_i        (al_off_s),
        .sdata_i      (store_data),
        .rdata_i      (mem_rdata),
        .be_o         (al_be_s),
        .wdata_o      (al_wdata_s),
        .ldata_o      (al_ldata_s),
        .misaligned_o (al_mis_s)
    );

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ea_q       <= 32'd0;
            rd_q       <= 5'd0;
            size_q     <= SZ_B;
            signed_q   <= 1'b0;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            req_ready  <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_be     <= 4'd0;
            mem_wdata  <= 32'd0;
            done_valid <= 1'b0;
            wb_en      <= 1'b0;
            wb_rd      <= 5'd0;
            wb_data    <= 32'd0;
            exc_valid  <= 1'b0;
            exc_cause  <= 4'd0;
            exc_tval   <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_valid <= 1'b0;
                    wb_en      <= 1'b0;
                    exc_valid  <= 1'b0;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        ea_q      <= ea_s;
                        rd_q      <= rd_in;
                        size_q    <= dec_size_s;
                        signed_q  <= dec_signed_s;
                        we_q      <= dec_we_s;
                        if (!legal_s) begin
                            state_q    <= ST_DONE;
                            done_valid <= 1'b1;
                            exc_valid  <= 1'b1;
                            exc_cause  <= CAUSE_ILLEGAL;
                            exc_tval   <= 32'd0;
                        end else if (al_mis_s) begin
                            state_q    <= ST_DONE;
                            done_valid <= 1'b1;
                            exc_valid  <= 1'b1;
                            exc_cause  <= dec_we_s ? ST_MISALIGN : LD_MISALIGN;
                            exc_tval   <= ea_s;
                        end else begin
                            state_q   <= ST_REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= dec_we_s;
                            mem_addr  <= {ea_s[31:2], 2'b00};
                            mem_be    <= al_be_s;
                            mem_wdata <= al_wdata_s;
                            cnt_q     <= '0;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // Error takes priority over a simultaneous ack; timeout is reported as a bus fault.
                    if (mem_err || (!mem_ack && (cnt_d == CNT_W'(TIMEOUT_CYC)))) begin
                        state_q    <= ST_DONE;
                        mem_req    <= 1'b0;
                        done_valid <= 1'b1;
                        exc_valid  <= 1'b1;
                        exc_cause  <= we_q ? ST_FAULT : LD_FAULT;
                        exc_tval   <= ea_q;
                    end else if (mem_ack) begin
                        state_q    <= ST_DONE;
                        mem_req    <= 1'b0;
                        done_valid <= 1'b1;
                        wb_en      <= !we_q;
                        wb_rd      <= rd_q;
                        wb_data    <= al_ldata_s;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_DONE: begin
                    state_q    <= ST_IDLE;
                    done_valid <= 1'b0;
                    wb_en      <= 1'b0;
                    exc_valid  <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    mem_req    <= 1'b0;
                    done_valid <= 1'b0;
                    wb_en      <= 1'b0;
                    exc_valid  <= 1'b0;
                    req_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl.
module tb_lsu_ctrl;

    localparam int TIMEOUT = 64;

    localparam logic [7:0] OP_LB  = 8'b1000_0000;
    localparam logic [7:0] OP_LH  = 8'b0100_0000;
    localparam logic [7:0] OP_LW  = 8'b0010_0000;
    localparam logic [7:0] OP_LBU = 8'b0001_0000;
    localparam logic [7:0] OP_SB  = 8'b0000_0100;
    localparam logic [7:0] OP_SH  = 8'b0000_0010;
    localparam logic [7:0] OP_SW  = 8'b0000_0001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        is_lb = 1'b0, is_lh = 1'b0, is_lw = 1'b0, is_lbu = 1'b0, is_lhu = 1'b0;
    logic        is_sb = 1'b0, is_sh = 1'b0, is_sw = 1'b0;
    logic [31:0] base = 32'd0, offset = 32'd0, store_data = 32'd0;
    logic [4:0]  rd_in = 5'd0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0, mem_err = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        done_valid, wb_en, exc_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, exc_tval;
    logic [3:0]  exc_cause;

    int n_assert = 0;
    int n_fail   = 0;
    int req_cyc;

    always #5 clk = ~clk;

    lsu_ctrl #(.TIMEOUT_CYC(TIMEOUT), .CNT_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .is_lb(is_lb), .is_lh(is_lh), .is_lw(is_lw), .is_lbu(is_lbu), .is_lhu(is_lhu),
        .is_sb(is_sb), .is_sh(is_sh), .is_sw(is_sw),
        .base(base), .offset(offset), .store_data(store_data), .rd_in(rd_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .done_valid(done_valid), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] op, input logic [31:0] b, input logic [31:0] o,
                         input logic [31:0] sd, input logic [4:0] rd);
        {is_lb, is_lh, is_lw, is_lbu, is_lhu, is_sb, is_sh, is_sw} = op;
        base       = b;
        offset     = o;
        store_data = sd;
        rd_in      = rd;
        req_valid  = 1'b1;
        tick();
        req_valid  = 1'b0;
        {is_lb, is_lh, is_lw, is_lbu, is_lhu, is_sb, is_sh, is_sw} = 8'd0;
    endtask

    task automatic respond(input logic ack, input logic err, input logic [31:0] rdata);
        mem_ack   = ack;
        mem_err   = err;
        mem_rdata = rdata;
        tick();
        mem_ack   = 1'b0;
        mem_err   = 1'b0;
    endtask

    // After a completion pulse: pulse must drop and the port must be ready again.
    task automatic back_to_idle(input string tag);
        tick();
        chk({tag, "_done_drop"}, {31'd0, done_valid}, 32'd0);
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_done", {31'd0, done_valid}, 32'd0);
        chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
        chk("rst_exc", {31'd0, exc_valid}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // lw 0x1000+4, ack three cycles after mem_req rises
        issue(OP_LW, 32'h0000_1000, 32'h0000_0004, 32'd0, 5'd5);
        chk("lw_req", {31'd0, mem_req}, 32'd1);
        chk("lw_ready_low", {31'd0, req_ready}, 32'd0);
        chk("lw_addr", mem_addr, 32'h0000_1004);
        chk("lw_be", {28'd0, mem_be}, 32'h0000_000F);
        chk("lw_we", {31'd0, mem_we}, 32'd0);
        tick();
        tick();
        chk("lw_addr_stable", mem_addr, 32'h0000_1004);
        chk("lw_no_early_done", {31'd0, done_valid}, 32'd0);
        respond(1'b1, 1'b0, 32'hDEAD_BEEF);
        chk("lw_done", {31'd0, done_valid}, 32'd1);
        chk("lw_wb_en", {31'd0, wb_en}, 32'd1);
        chk("lw_wb_data", wb_data, 32'hDEAD_BEEF);
        chk("lw_wb_rd", {27'd0, wb_rd}, 32'd5);
        chk("lw_exc", {31'd0, exc_valid}, 32'd0);
        chk("lw_req_drop", {31'd0, mem_req}, 32'd0);
        back_to_idle("lw");

        // lb at EA 0x2003
        issue(OP_LB, 32'h0000_2000, 32'h0000_0003, 32'd0, 5'd7);
        chk("lb_be", {28'd0, mem_be}, 32'h0000_0008);
        chk("lb_addr", mem_addr, 32'h0000_2000);
        respond(1'b1, 1'b0, 32'h80FF_FFFF);
        chk("lb_wb_data", wb_data, 32'hFFFF_FF80);
        chk("lb_wb_rd", {27'd0, wb_rd}, 32'd7);
        back_to_idle("lb");

        // lbu at EA 0x2003 reached through a negative offset
        issue(OP_LBU, 32'h0000_2004, 32'hFFFF_FFFF, 32'd0, 5'd8);
        chk("lbu_be", {28'd0, mem_be}, 32'h0000_0008);
        respond(1'b1, 1'b0, 32'h80FF_FFFF);
        chk("lbu_wb_data", wb_data, 32'h0000_0080);
        chk("lbu_wb_en", {31'd0, wb_en}, 32'd1);
        back_to_idle("lbu");

        // sh at EA 0x3002
        issue(OP_SH, 32'h0000_3000, 32'h0000_0002, 32'h0000_ABCD, 5'd1);
        chk("sh_we", {31'd0, mem_we}, 32'd1);
        chk("sh_be", {28'd0, mem_be}, 32'h0000_000C);
        chk("sh_wdata", mem_wdata, 32'hABCD_ABCD);
        respond(1'b1, 1'b0, 32'h1111_1111);
        chk("sh_done", {31'd0, done_valid}, 32'd1);
        chk("sh_wb_en", {31'd0, wb_en}, 32'd0);
        chk("sh_exc", {31'd0, exc_valid}, 32'd0);
        back_to_idle("sh");

        // lh at EA 0x7002 with rd = 0 still writes back
        issue(OP_LH, 32'h0000_7000, 32'h0000_0002, 32'd0, 5'd0);
        chk("lh_be", {28'd0, mem_be}, 32'h0000_000C);
        respond(1'b1, 1'b0, 32'h8001_1234);
        chk("lh_wb_data", wb_data, 32'hFFFF_8001);
        chk("lh_wb_en_rd0", {31'd0, wb_en}, 32'd1);
        back_to_idle("lh");

        // misaligned lw
        issue(OP_LW, 32'h0000_4000, 32'h0000_0001, 32'd0, 5'd3);
        chk("lwmis_no_req", {31'd0, mem_req}, 32'd0);
        chk("lwmis_done", {31'd0, done_valid}, 32'd1);
        chk("lwmis_exc", {31'd0, exc_valid}, 32'd1);
        chk("lwmis_cause", {28'd0, exc_cause}, 32'd4);
        chk("lwmis_tval", exc_tval, 32'h0000_4001);
        chk("lwmis_wb_en", {31'd0, wb_en}, 32'd0);
        back_to_idle("lwmis");

        // misaligned sw
        issue(OP_SW, 32'h0000_4000, 32'h0000_0002, 32'h1234_5678, 5'd0);
        chk("swmis_no_req", {31'd0, mem_req}, 32'd0);
        chk("swmis_cause", {28'd0, exc_cause}, 32'd6);
        chk("swmis_tval", exc_tval, 32'h0000_4002);
        back_to_idle("swmis");

        // sb with ack and err together
        issue(OP_SB, 32'h0000_5000, 32'h0000_0001, 32'h1234_5677, 5'd0);
        chk("sb_be", {28'd0, mem_be}, 32'h0000_0002);
        chk("sb_wdata", mem_wdata, 32'h7777_7777);
        respond(1'b1, 1'b1, 32'd0);
        chk("sberr_done", {31'd0, done_valid}, 32'd1);
        chk("sberr_exc", {31'd0, exc_valid}, 32'd1);
        chk("sberr_cause", {28'd0, exc_cause}, 32'd7);
        chk("sberr_tval", exc_tval, 32'h0000_5001);
        chk("sberr_wb_en", {31'd0, wb_en}, 32'd0);
        back_to_idle("sberr");

        // lw with no response: count REQ cycles
        issue(OP_LW, 32'h0000_6000, 32'h0000_0008, 32'd0, 5'd9);
        req_cyc = 0;
        while (mem_req && req_cyc < 4 * TIMEOUT) begin
            tick();
            req_cyc++;
        end
        chk("to_req_cycles", req_cyc, TIMEOUT);
        chk("to_done", {31'd0, done_valid}, 32'd1);
        chk("to_cause", {28'd0, exc_cause}, 32'd5);
        chk("to_tval", exc_tval, 32'h0000_6008);
        back_to_idle("to");

        // two strobes set
        issue(OP_LW | OP_SW, 32'h0000_1000, 32'd0, 32'd0, 5'd2);
        chk("ill2_no_req", {31'd0, mem_req}, 32'd0);
        chk("ill2_done", {31'd0, done_valid}, 32'd1);
        chk("ill2_cause", {28'd0, exc_cause}, 32'd2);
        chk("ill2_tval", exc_tval, 32'd0);
        back_to_idle("ill2");

        // no strobe set
        issue(8'd0, 32'h0000_1000, 32'd0, 32'd0, 5'd2);
        chk("ill0_no_req", {31'd0, mem_req}, 32'd0);
        chk("ill0_cause", {28'd0, exc_cause}, 32'd2);
        back_to_idle("ill0");

        // reset while in REQ
        issue(OP_LW, 32'h0000_8000, 32'd0, 32'd0, 5'd4);
        chk("rstreq_req", {31'd0, mem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstreq_req_drop", {31'd0, mem_req}, 32'd0);
        chk("rstreq_no_done", {31'd0, done_valid}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rstreq_no_done2", {31'd0, done_valid}, 32'd0);
        chk("rstreq_ready", {31'd0, req_ready}, 32'd1);
        tick();
        chk("rstreq_no_done3", {31'd0, done_valid}, 32'd0);
        chk("rstreq_idle_req", {31'd0, mem_req}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
